mux_select_sequencer: RTL and testbench
=======================================

# mux_select_sequencer

Upstream driver for the 9-to-1 bit multiplexer. It latches a 9-bit word on a start request and steps the mux select code through 1..9, holding each code for a programmable number of cycles. Between frames it parks select at 0, which forces the mux output to 0. It reports progress with busy/strobe/done signals so a downstream serial consumer can sample the mux output.

## Interface
Parameters:
- HOLD_W, default 8: width of the per-bit hold count.

Ports:
- clk  input  1  the only clock; everything is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request one frame; sampled only in IDLE.
- abort  input  1  terminate the current frame immediately, with no done pulse.
- loop_en  input  1  when 1, frames repeat back-to-back until abort or loop_en=0.
- hold_cycles  input  HOLD_W  extra cycles per bit; each bit lasts hold_cycles+1 cycles.
- data_in  input  9  word to serialise.
- data_latched  output  9  frozen copy of the word; drives the mux data input.
- select  output  4  mux select code; 0 when idle, 1..9 during a frame.
- busy  output  1  high while a frame is active.
- bit_strobe  output  1  high on the last cycle of each bit's hold; this is the sample point.
- done  output  1  one-cycle pulse after a frame completes without looping.

## Operation
- States are IDLE and RUN.
- Internal registers:
  - hold_q (HOLD_W): the latched hold_cycles value.
  - cnt (HOLD_W): down-counter for the current bit.
- Reset values: select=0, data_latched=0, busy=0, bit_strobe=0, done=0, hold_q=0, cnt=0, state=IDLE.
- IDLE behaviour:
  - select=0, busy=0.
  - If start=1 at an edge: data_latched<=data_in, hold_q<=hold_cycles, cnt<=hold_cycles, select<=1, busy<=1, state<=RUN.
- RUN behaviour, per edge:
  - If cnt≠0: cnt<=cnt-1 and select holds.
  - If cnt=0 and select<9: select<=select+1 and cnt<=hold_q.
  - If cnt=0 and select=9 and loop_en=1: data_latched<=data_in, hold_q<=hold_cycles, cnt<=hold_cycles, select<=1. There is no gap cycle and no done pulse.
  - If cnt=0 and select=9 and loop_en=0: select<=0, busy<=0, done<=1 for one cycle, state<=IDLE.
- bit_strobe is combinational: bit_strobe = (state==RUN) && (cnt==0).
- start is ignored while in RUN.
- data_in and hold_cycles changes during a frame have no effect until the next latch point.
- abort in RUN takes effect at the next edge: select<=0, busy<=0, done stays 0, state<=IDLE. data_latched retains its value.
- Precedence: rst > abort > normal sequencing.
- abort and start asserted together in IDLE: abort wins and no frame starts.
- select never takes the values 10..15.
- cnt arithmetic is unsigned HOLD_W and never underflows: it is only decremented when nonzero.

## Timing
- Latency: start sampled at edge E0 gives select=1 and busy=1 visible after E0.
- A frame is 9×(hold_cycles+1) cycles long.
- After the last bit (non-loop): done=1 and select=0 in the following cycle. done is low on the next edge.
- In IDLE, start may be reasserted in the same cycle that done=1; the new frame begins on that edge.
- hold_cycles=0: select advances every cycle and bit_strobe stays high for all 9 cycles.
- hold_cycles at its maximum (2^HOLD_W−1): each bit lasts 2^HOLD_W cycles. No overflow occurs.
- rst asserted mid-frame: all outputs return to their reset values on that edge.

## Test plan
- Reset with start=1 held: after rst is released, select=0, busy=0, data_latched=0.
- Basic frame: data_in=9'h1A5, hold_cycles=0, start pulse.
  - select reads 1,2,…,9 on consecutive cycles, with bit_strobe=1 each cycle.
  - The mux output stream is 1,0,1,0,0,1,0,1,1.
  - The next cycle has done=1 and select=0.
- Hold timing: hold_cycles=3.
  - Each select value is stable for 4 cycles, with bit_strobe only on the 4th.
  - The frame lasts 36 cycles and done appears at cycle 37.
- Latch isolation: data_in changes to 9'h000 and hold_cycles to 7 mid-frame.
  - data_latched stays at 9'h1A5.
  - Bit duration stays unchanged.
- Loop mode: loop_en=1 with data_in stepping each frame.
  - select wraps from 9 to 1 with no gap and no done pulse.
  - A new word is latched at each wrap.
  - Clearing loop_en ends the frame after the current one, followed by done.
- Abort and reset mid-frame: abort at select=5 gives select=0, busy=0, and done never pulses. rst at select=3 gives full reset values. start during RUN is ignored.

Source files
------------

// File: rtl/mux_select_sequencer.sv
// Drives the select code of a 9-to-1 bit mux: latches a word, steps select 1..9 with a
// programmable per-bit hold, and parks select at 0 between frames.
module mux_select_sequencer #(
  parameter int unsigned HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              loop_en,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic [8:0]        data_in,
  output logic [8:0]        data_latched,
  output logic [3:0]        select,
  output logic              busy,
  output logic              bit_strobe,
  output logic              done
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [HOLD_W-1:0] CntOne  = HOLD_W'(1);
  localparam logic [3:0]        SelLast = 4'd9;

  state_e            state;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      select       <= 4'd0;
      data_latched <= 9'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      hold_q       <= '0;
      cnt          <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          // abort outranks a simultaneous start
          if (start && !abort) begin
            data_latched <= data_in;
            hold_q       <= hold_cycles;
            cnt          <= hold_cycles;
            select       <= 4'd1;
            busy         <= 1'b1;
            state        <= StRun;
          end
        end
        StRun: begin
          if (abort) begin
            select <= 4'd0;
            busy   <= 1'b0;
            state  <= StIdle;
          end else if (cnt != '0) begin
            cnt <= cnt - CntOne;
          end else if (select < SelLast) begin
            select <= select + 4'd1;
            cnt    <= hold_q;
          end else if (loop_en) begin
            // wrap straight into the next frame with a freshly latched word
            data_latched <= data_in;
            hold_q       <= hold_cycles;
            cnt          <= hold_cycles;
            select       <= 4'd1;
          end else begin
            select <= 4'd0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bit_strobe = (state == StRun) && (cnt == '0);

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Self-checking bench for mux_select_sequencer: table vectors, corner sequences, and random
// stimulus against a frame-position reference model.
module tb_mux_select_sequencer;
  localparam int unsigned HW = 8;

  logic          clk = 1'b0;
  logic          rst, start, abort, loop_en;
  logic [HW-1:0] hold_cycles;
  logic [8:0]    data_in, data_latched;
  logic [3:0]    select;
  logic          busy, bit_strobe, done;

  mux_select_sequencer #(.HOLD_W(HW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .loop_en      (loop_en),
    .hold_cycles  (hold_cycles),
    .data_in      (data_in),
    .data_latched (data_latched),
    .select       (select),
    .busy         (busy),
    .bit_strobe   (bit_strobe),
    .done         (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: frame position as a plain cycle index within the frame.
  bit       m_active;
  bit       m_done;
  int       m_t;
  int       m_hold;
  bit [8:0] m_latched;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int frame_len(int h);
    return 9 * (h + 1);
  endfunction

  function automatic void model_step();
    if (rst) begin
      m_active = 0; m_done = 0; m_t = 0; m_hold = 0; m_latched = '0;
    end else begin
      m_done = 0;
      if (!m_active) begin
        if (start && !abort) begin
          m_active = 1; m_t = 0; m_hold = int'(hold_cycles); m_latched = data_in;
        end
      end else if (abort) begin
        m_active = 0;
      end else if (m_t == frame_len(m_hold) - 1) begin
        if (loop_en) begin
          m_t = 0; m_hold = int'(hold_cycles); m_latched = data_in;
        end else begin
          m_active = 0; m_done = 1;
        end
      end else begin
        m_t++;
      end
    end
  endfunction

  function automatic int dut_mux();
    if (select >= 4'd1 && select <= 4'd9) return int'(data_latched[select - 4'd1]);
    return 0;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_select", int'(select), m_active ? m_t / (m_hold + 1) + 1 : 0);
    chk("model_busy", int'(busy), int'(m_active));
    chk("model_strobe", int'(bit_strobe), (m_active && (m_t % (m_hold + 1) == m_hold)) ? 1 : 0);
    chk("model_done", int'(done), int'(m_done));
    chk("model_latched", int'(data_latched), int'(m_latched));
  endtask

  task automatic wait_select(int v, int budget);
    int n = 0;
    while (int'(select) != v && n < budget) begin
      tick();
      n++;
    end
    chk("wait_select_timeout", int'(select), v);
  endtask

  // Ticks until done, returning the number of edges taken (the start edge counts as 1).
  task automatic run_to_done(int budget, output int n);
    n = 1;
    while (!done && n < budget) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    logic       st;
    logic [3:0] sel;
    logic       bsy;
    logic       stb;
    logic       dn;
    int         mux;
  } vec_t;

  vec_t vecs[11];
  int   stream[9];

  initial begin
    int n;
    int dones;
    int strobes;

    stream = '{1, 0, 1, 0, 0, 1, 0, 1, 1};
    vecs[0] = '{1'b1, 4'd1, 1'b1, 1'b1, 1'b0, stream[0]};
    for (int i = 1; i < 9; i++) vecs[i] = '{1'b0, 4'(i + 1), 1'b1, 1'b1, 1'b0, stream[i]};
    vecs[9]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 0};
    vecs[10] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 0};

    // Reset with start held high
    rst = 1; start = 1; abort = 0; loop_en = 0; hold_cycles = '0; data_in = 9'h1FF;
    tick(); tick();
    rst = 0; start = 0;
    tick();
    chk("rst_select", int'(select), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_latched", int'(data_latched), 0);

    // Basic frame from the table
    data_in = 9'h1A5; hold_cycles = '0;
    for (int i = 0; i < 11; i++) begin
      start = vecs[i].st;
      tick();
      chk("tbl_select", int'(select), int'(vecs[i].sel));
      chk("tbl_busy", int'(busy), int'(vecs[i].bsy));
      chk("tbl_strobe", int'(bit_strobe), int'(vecs[i].stb));
      chk("tbl_done", int'(done), int'(vecs[i].dn));
      chk("tbl_mux", dut_mux(), vecs[i].mux);
    end
    start = 0;

    // Hold timing with latch isolation mid-frame
    data_in = 9'h1A5; hold_cycles = 8'd3; start = 1;
    tick();
    start = 0;
    strobes = int'(bit_strobe);
    n = 1;
    while (!done && n < 200) begin
      if (n == 10) begin
        data_in = 9'h000; hold_cycles = 8'd7;
      end
      tick();
      n++;
      if (busy) strobes += int'(bit_strobe);
      if (n == 20) chk("iso_latched", int'(data_latched), 9'h1A5);
    end
    chk("hold3_done_cycle", n, 37);
    chk("hold3_strobes", strobes, 9);
    tick();

    // Start and done in the same cycle: back-to-back frame
    data_in = 9'h055; hold_cycles = '0; start = 1;
    tick();
    start = 0;
    run_to_done(50, n);
    start = 1; data_in = 9'h0AA;
    tick();
    start = 0;
    chk("b2b_select", int'(select), 1);
    chk("b2b_latched", int'(data_latched), 9'h0AA);
    run_to_done(50, n);
    tick();

    // Loop mode
    loop_en = 1; hold_cycles = 8'd1; data_in = 9'h101; start = 1;
    tick();
    start = 0;
    dones = 0;
    for (int f = 0; f < 3; f++) begin
      data_in = 9'(9'h102 + f);
      for (int k = 0; k < 17; k++) begin
        tick();
        dones += int'(done);
      end
      chk("loop_last_select", int'(select), 9);
      tick();
      dones += int'(done);
      chk("loop_wrap_select", int'(select), 1);
      chk("loop_wrap_latched", int'(data_latched), 9'h102 + f);
    end
    chk("loop_no_done", dones, 0);
    loop_en = 0;
    for (int k = 0; k < 18; k++) tick();
    chk("loop_exit_done", int'(done), 1);
    tick();

    // Abort at select 5, then abort+start in idle
    data_in = 9'h0F0; hold_cycles = 8'd2; start = 1;
    tick();
    start = 0;
    wait_select(5, 40);
    abort = 1;
    tick();
    abort = 0;
    chk("abort_select", int'(select), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_latched", int'(data_latched), 9'h0F0);
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      dones += int'(done);
    end
    chk("abort_no_done", dones, 0);
    abort = 1; start = 1;
    tick();
    abort = 0; start = 0;
    chk("abort_start_busy", int'(busy), 0);

    // Reset mid-frame at select 3
    data_in = 9'h0F3; hold_cycles = 8'd1; start = 1;
    tick();
    start = 0;
    wait_select(3, 40);
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_select", int'(select), 0);
    chk("midrst_latched", int'(data_latched), 0);
    chk("midrst_busy", int'(busy), 0);

    // start during RUN is ignored
    data_in = 9'h111; hold_cycles = 8'd1; start = 1;
    tick();
    start = 0;
    tick(); tick(); tick();
    start = 1; data_in = 9'h0AA;
    tick(); tick();
    start = 0;
    chk("run_start_latched", int'(data_latched), 9'h111);
    run_to_done(50, n);
    tick();

    // Maximum hold: each bit lasts 256 cycles
    hold_cycles = 8'hFF; data_in = 9'h1C3; start = 1;
    tick();
    start = 0;
    run_to_done(3000, n);
    chk("maxhold_done_cycle", n, 2305);
    tick();

    // Random stimulus
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom % 97) == 0;
      abort       = ($urandom % 40) == 0;
      start       = ($urandom % 4) == 0;
      loop_en     = ($urandom % 3) == 0;
      hold_cycles = HW'($urandom_range(0, 3));
      data_in     = 9'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
